// File: rtl/quote_generator_pkg.sv
// quote_generator_pkg
//   Shared definitions for the quote generator: default fixed-point word
//   width (Q32.32), fraction-bit count, saturation limits for the default
//   width and the FSM state encoding.
//   No ports (package).
package quote_generator_pkg;

  localparam int FP_WORD_SIZE = 64;
  localparam int FRAC_BITS    = 32;

  localparam logic signed [FP_WORD_SIZE-1:0] FP_SAT_MAX = {1'b0, {(FP_WORD_SIZE-1){1'b1}}};
  localparam logic signed [FP_WORD_SIZE-1:0] FP_SAT_MIN = {1'b1, {(FP_WORD_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SPR = 3'd1,
    WAIT_RES = 3'd2,
    CALC     = 3'd3,
    OUT      = 3'd4
  } state_t;

endpackage

// File: rtl/quote_generator_tick_rounder.sv
// tick_rounder
//   Aligns one price to a multiple of 2^TICK_SHIFT LSBs and saturates the
//   result into the signed W-bit range. Purely combinational.
//   Ports:
//     value     : W+1 bit signed raw price (one guard bit so res +/- half
//                 never wraps before rounding)
//     ceil_mode : 0 = floor to the tick below, 1 = ceiling to the tick above
//     result    : W bit signed aligned, saturated price
//   TICK_SHIFT must be at least 1.
module tick_rounder #(
  parameter int W          = 64,
  parameter int TICK_SHIFT = 24
) (
  input  logic signed [W:0]   value,
  input  logic                ceil_mode,
  output logic signed [W-1:0] result
);

  // Work in W+2 bits: the guard bit from the caller plus one more so the
  // ceiling bias cannot overflow.
  localparam logic signed [W+1:0] TICK_M1 = {{(W+2-TICK_SHIFT){1'b0}}, {TICK_SHIFT{1'b1}}};
  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] ext;
  logic signed [W+1:0] biased;
  logic signed [W+1:0] aligned;

  always_comb begin
    ext     = {value[W], value};
    // Two's complement masking is a floor for either sign; adding
    // (tick - 1) first turns it into a ceiling.
    biased  = ceil_mode ? (ext + TICK_M1) : ext;
    aligned = biased & ~TICK_M1;
    if (aligned > SAT_MAX) begin
      result = SAT_MAX[W-1:0];
    end else if (aligned < SAT_MIN) begin
      result = SAT_MIN[W-1:0];
    end else begin
      result = aligned[W-1:0];
    end
  end

endmodule

// File: rtl/quote_generator.sv
// quote_generator
//   Pairs a reservation price with an optimal spread, then emits a
//   tick-aligned bid/ask quote: bid = floor(res - half), ask = ceil(res + half),
//   half = max(spread, 0) >>> 1, both saturated to the signed word range.
//   An operand left unpaired for TIMEOUT_CYCLES cycles is discarded with a
//   one-cycle o_timeout pulse.
//
//   Handshake: i_res_valid / i_spread_valid are one-cycle qualifiers sampled
//   on the rising edge; they are ignored while the block is in CALC or OUT.
//   o_quote_valid stays high with o_bid_price/o_ask_price frozen until a
//   rising edge sees i_ready=1; that edge consumes the quote.
//
//   Ports:
//     i_clk, i_rst_n             : clock, asynchronous active-low reset
//     i_reservation_price/_valid : reservation price and qualifier
//     i_spread/i_spread_valid    : optimal spread and qualifier
//     i_ready                    : downstream ready
//     o_bid_price, o_ask_price   : registered quotes, o_quote_valid qualifier
//     o_timeout                  : one-cycle pulse on operand discard
//     o_busy                     : high in CALC and OUT
//     o_state                    : current FSM state (debug observation)
//
//   Optional feature: define QUOTE_MIN_SPREAD_EN to force ask >= bid + 1 tick.
module quote_generator #(
  parameter int FP_WORD_SIZE   = quote_generator_pkg::FP_WORD_SIZE,
  parameter int TICK_SHIFT     = 24,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic signed [FP_WORD_SIZE-1:0] i_reservation_price,
  input  logic                           i_res_valid,
  input  logic signed [FP_WORD_SIZE-1:0] i_spread,
  input  logic                           i_spread_valid,
  input  logic                           i_ready,
  output logic signed [FP_WORD_SIZE-1:0] o_bid_price,
  output logic signed [FP_WORD_SIZE-1:0] o_ask_price,
  output logic                           o_quote_valid,
  output logic                           o_timeout,
  output logic                           o_busy,
  output quote_generator_pkg::state_t    o_state
);

  import quote_generator_pkg::*;

  localparam int W  = FP_WORD_SIZE;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic signed [W-1:0] res_q, res_d;
  logic signed [W-1:0] spr_q, spr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] bid_d, ask_d;
  logic                qv_d, to_d;

  // Datapath, evaluated from the latched operands and captured in CALC.
  logic signed [W-1:0] half;
  logic signed [W:0]   bid_raw, ask_raw;
  logic signed [W-1:0] bid_r, ask_r, ask_fin;

  assign half    = spr_q[W-1] ? '0 : (spr_q >>> 1);
  assign bid_raw = {res_q[W-1], res_q} - {half[W-1], half};
  assign ask_raw = {res_q[W-1], res_q} + {half[W-1], half};

  tick_rounder #(.W(W), .TICK_SHIFT(TICK_SHIFT)) u_bid_round (
    .value     (bid_raw),
    .ceil_mode (1'b0),
    .result    (bid_r)
  );

  tick_rounder #(.W(W), .TICK_SHIFT(TICK_SHIFT)) u_ask_round (
    .value     (ask_raw),
    .ceil_mode (1'b1),
    .result    (ask_r)
  );

`ifdef QUOTE_MIN_SPREAD_EN
  localparam logic signed [W:0] TICK_X = {{W{1'b0}}, 1'b1} << TICK_SHIFT;
  localparam logic signed [W:0] MAX_X  = {2'b00, {(W-1){1'b1}}};

  logic signed [W:0] gap;
  logic signed [W:0] bump;

  always_comb begin
    gap  = {ask_r[W-1], ask_r} - {bid_r[W-1], bid_r};
    bump = {bid_r[W-1], bid_r} + TICK_X;
    if (gap < TICK_X) begin
      ask_fin = (bump > MAX_X) ? MAX_X[W-1:0] : bump[W-1:0];
    end else begin
      ask_fin = ask_r;
    end
  end
`else
  assign ask_fin = ask_r;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    spr_d   = spr_q;
    cnt_d   = cnt_q;
    bid_d   = o_bid_price;
    ask_d   = o_ask_price;
    qv_d    = o_quote_valid;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_res_valid && i_spread_valid) begin
          res_d   = i_reservation_price;
          spr_d   = i_spread;
          state_d = CALC;
        end else if (i_res_valid) begin
          res_d   = i_reservation_price;
          state_d = WAIT_SPR;
        end else if (i_spread_valid) begin
          spr_d   = i_spread;
          state_d = WAIT_RES;
        end
      end
      WAIT_SPR: begin
        // Pairing takes priority over a pending timeout on the same edge.
        if (i_spread_valid) begin
          spr_d   = i_spread;
          if (i_res_valid) res_d = i_reservation_price;
          state_d = CALC;
        end else if (i_res_valid) begin
          res_d = i_reservation_price;
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          res_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_RES: begin
        if (i_res_valid) begin
          res_d   = i_reservation_price;
          if (i_spread_valid) spr_d = i_spread;
          state_d = CALC;
        end else if (i_spread_valid) begin
          spr_d = i_spread;
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          spr_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CALC: begin
        bid_d   = bid_r;
        ask_d   = ask_fin;
        qv_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (i_ready) begin
          qv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      res_q         <= '0;
      spr_q         <= '0;
      cnt_q         <= '0;
      o_bid_price   <= '0;
      o_ask_price   <= '0;
      o_quote_valid <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      state_q       <= state_d;
      res_q         <= res_d;
      spr_q         <= spr_d;
      cnt_q         <= cnt_d;
      o_bid_price   <= bid_d;
      o_ask_price   <= ask_d;
      o_quote_valid <= qv_d;
      o_timeout     <= to_d;
    end
  end

  assign o_busy  = (state_q == CALC) || (state_q == OUT);
  assign o_state = state_q;

endmodule

// File: tb/tb_quote_generator.sv
// tb_quote_generator
//   Directed and randomized checks of quote_generator (Q32.32, tick 2^-8)
//   against a reference model built from floor/ceil division on wide
//   integers. Honours QUOTE_MIN_SPREAD_EN in the same way as the design.
module tb_quote_generator;

  import quote_generator_pkg::*;

  logic               clk;
  logic               rst_n;
  logic signed [63:0] res;
  logic               res_v;
  logic signed [63:0] spr;
  logic               spr_v;
  logic               ready;
  logic signed [63:0] bid;
  logic signed [63:0] ask;
  logic               qv;
  logic               tmo;
  logic               busy;
  state_t             st;

  int n_cmp;
  int n_err;

  localparam logic signed [127:0] TICK = 128'sd1 <<< 24;

  quote_generator #(
    .FP_WORD_SIZE   (64),
    .TICK_SHIFT     (24),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_reservation_price (res),
    .i_res_valid         (res_v),
    .i_spread            (spr),
    .i_spread_valid      (spr_v),
    .i_ready             (ready),
    .o_bid_price         (bid),
    .o_ask_price         (ask),
    .o_quote_valid       (qv),
    .o_timeout           (tmo),
    .o_busy              (busy),
    .o_state             (st)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic signed [63:0] fx(input real r);
    return 64'(longint'(r * (2.0 ** FRAC_BITS)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bid"}, bid, 64'd0);
    check({tag, "_ask"}, ask, 64'd0);
    check({tag, "_qv"}, {63'd0, qv}, 64'd0);
    check({tag, "_tmo"}, {63'd0, tmo}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_state"}, 64'(st), 64'(IDLE));
  endtask

  task automatic drive(input logic rv, input logic signed [63:0] r,
                       input logic sv, input logic signed [63:0] s);
    res_v = rv; res = r;
    spr_v = sv; spr = s;
  endtask

  task automatic quiet();
    res_v = 1'b0;
    spr_v = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] clamp(input logic signed [127:0] x);
    logic signed [127:0] mx, mn;
    mx = FP_SAT_MAX;
    mn = FP_SAT_MIN;
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

  function automatic logic signed [127:0] floor_tick(input logic signed [127:0] x);
    logic signed [127:0] q;
    q = x / TICK;
    if ((x % TICK) != 0 && x < 0) q = q - 1;
    return q * TICK;
  endfunction

  function automatic logic signed [127:0] ceil_tick(input logic signed [127:0] x);
    logic signed [127:0] q;
    q = x / TICK;
    if ((x % TICK) != 0 && x > 0) q = q + 1;
    return q * TICK;
  endfunction

  task automatic model(input logic signed [63:0] r_in, input logic signed [63:0] s_in,
                       output logic signed [63:0] b_out, output logic signed [63:0] a_out);
    logic signed [127:0] r, s, h, b, a;
    r = r_in;
    s = s_in;
    h = (s < 0) ? 128'sd0 : s / 2;
    b = clamp(floor_tick(r - h));
    a = clamp(ceil_tick(r + h));
`ifdef QUOTE_MIN_SPREAD_EN
    if (a - b < TICK) a = clamp(b + TICK);
`endif
    b_out = b[63:0];
    a_out = a[63:0];
  endtask

  // Present a pair in the given order/gap, check latency and values, consume.
  task automatic run_pair(input string tag, input logic signed [63:0] r,
                          input logic signed [63:0] s, input int order,
                          input int gap, input int rdelay);
    logic signed [63:0] eb, ea;
    model(r, s, eb, ea);
    ready = 1'b0;
    case (order)
      1: begin
        drive(1'b1, r, 1'b0, 64'd0); tick(); quiet();
        repeat (gap - 1) tick();
        drive(1'b0, 64'd0, 1'b1, s); tick(); quiet();
      end
      2: begin
        drive(1'b0, 64'd0, 1'b1, s); tick(); quiet();
        repeat (gap - 1) tick();
        drive(1'b1, r, 1'b0, 64'd0); tick(); quiet();
      end
      default: begin
        drive(1'b1, r, 1'b1, s); tick(); quiet();
      end
    endcase
    check({tag, "_calc_qv"}, {63'd0, qv}, 64'd0);
    tick();
    check({tag, "_qv"}, {63'd0, qv}, 64'd1);
    check({tag, "_bid"}, bid, eb);
    check({tag, "_ask"}, ask, ea);
    repeat (rdelay) tick();
    check({tag, "_held_ask"}, ask, ea);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_consumed"}, {63'd0, qv}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic signed [63:0] sb, sa, rr, ss;
    logic               bad;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 64'd0);
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Same-cycle pair: 100.0 / 0.5.
    ready = 1'b1;
    drive(1'b1, fx(100.0), 1'b1, fx(0.5));
    tick(); quiet();
    check("t1_calc_qv", {63'd0, qv}, 64'd0);
    check("t1_calc_busy", {63'd0, busy}, 64'd1);
    tick();
    check("t1_qv", {63'd0, qv}, 64'd1);
    check("t1_bid", bid, fx(99.75));
    check("t1_ask", ask, fx(100.25));
    tick();
    check("t1_consumed", {63'd0, qv}, 64'd0);
    check("t1_idle", 64'(st), 64'(IDLE));

    // Price first, spread 0.001 three cycles later.
    ready = 1'b0;
    drive(1'b1, fx(100.0), 1'b0, 64'd0);
    tick(); quiet();
    check("t2_wait", 64'(st), 64'(WAIT_SPR));
    tick(); tick();
    drive(1'b0, 64'd0, 1'b1, fx(0.001));
    tick(); quiet();
    tick();
    check("t2_qv", {63'd0, qv}, 64'd1);
    check("t2_bid", bid, fx(99.99609375));
    check("t2_ask", ask, fx(100.00390625));
    ready = 1'b1; tick(); ready = 1'b0;

    // Zero spread.
    drive(1'b1, fx(100.0), 1'b1, 64'd0);
    tick(); quiet(); tick();
    check("t3_bid", bid, fx(100.0));
`ifdef QUOTE_MIN_SPREAD_EN
    check("t3_ask", ask, fx(100.00390625));
`else
    check("t3_ask", ask, fx(100.0));
`endif
    ready = 1'b1; tick(); ready = 1'b0;

    // Unpaired price: timeout exactly 16 cycles after the latching edge.
    drive(1'b1, fx(42.0), 1'b0, 64'd0);
    tick(); quiet();
    bad = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (tmo !== 1'b0 || qv !== 1'b0) bad = 1'b1;
    end
    check("t4_no_early_timeout", {63'd0, bad}, 64'd0);
    tick();
    check("t4_timeout", {63'd0, tmo}, 64'd1);
    check("t4_idle", 64'(st), 64'(IDLE));
    tick();
    check("t4_pulse_one_cycle", {63'd0, tmo}, 64'd0);
    check("t4_no_quote", {63'd0, qv}, 64'd0);

    // Spread re-arrival restarts the wait; second spread is the one used.
    drive(1'b0, 64'd0, 1'b1, fx(2.0));
    tick(); quiet();
    repeat (4) tick();
    drive(1'b0, 64'd0, 1'b1, fx(1.0));
    tick(); quiet();
    bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (tmo !== 1'b0) bad = 1'b1;
    end
    check("t5_restart_no_timeout", {63'd0, bad}, 64'd0);
    check("t5_wait", 64'(st), 64'(WAIT_RES));
    drive(1'b1, fx(10.0), 1'b0, 64'd0);
    tick(); quiet(); tick();
    check("t5_bid", bid, fx(9.5));
    check("t5_ask", ask, fx(10.5));
    ready = 1'b1; tick(); ready = 1'b0;

    // Back-pressure: outputs frozen for 5 cycles, extra inputs dropped.
    drive(1'b1, fx(-3.25), 1'b1, fx(0.75));
    tick(); quiet(); tick();
    model(fx(-3.25), fx(0.75), sb, sa);
    check("t6_bid", bid, sb);
    check("t6_ask", ask, sa);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom_range(0, 1)), 64'($urandom), 1'($urandom_range(0, 1)), 64'($urandom));
      tick();
      if (bid !== sb || ask !== sa || qv !== 1'b1 || st !== OUT) bad = 1'b1;
    end
    quiet();
    check("t6_stable", {63'd0, bad}, 64'd0);
    ready = 1'b1; tick(); ready = 1'b0;
    check("t6_consumed", {63'd0, qv}, 64'd0);
    tick();
    check("t6_dropped", 64'(st), 64'(IDLE));

    // Reset in WAIT_SPR aborts immediately, nothing emitted afterwards.
    drive(1'b1, fx(77.0), 1'b0, 64'd0);
    tick(); quiet();
    check("t7_wait", 64'(st), 64'(WAIT_SPR));
    #2 rst_n = 1'b0;
    #1 check_zero("t7_rst_wait");
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tmo !== 1'b0 || qv !== 1'b0) bad = 1'b1;
    end
    check("t7_silent", {63'd0, bad}, 64'd0);

    // Reset in OUT.
    drive(1'b1, fx(5.0), 1'b1, fx(1.0));
    tick(); quiet(); tick();
    check("t8_qv", {63'd0, qv}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("t8_rst_out");
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("t8_after_release");
    run_pair("t8_fresh", fx(100.0), fx(0.5), 0, 1, 1);

    // Saturation corners.
    run_pair("sat_hi", FP_SAT_MAX, FP_SAT_MAX, 0, 1, 0);
    run_pair("sat_lo", FP_SAT_MIN, FP_SAT_MAX, 1, 3, 0);
    run_pair("neg_spread", fx(1.0), fx(-4.0), 2, 2, 0);

    // Randomized pairs.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) rr = {$urandom, $urandom};
      else rr = 64'(longint'($signed($urandom))) <<< 8;
      case ($urandom_range(0, 3))
        0: ss = {$urandom, $urandom};
        1: ss = -64'($urandom);
        default: ss = 64'($urandom) <<< $urandom_range(0, 4);
      endcase
      run_pair($sformatf("rnd%0d", i), rr, ss, int'($urandom_range(0, 2)),
               int'($urandom_range(1, 14)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
